// File: rtl/uart_tx_ctrl.sv
// UART transmit sequencer: frames one byte per handshake and paces each bit off the baud generator.
// Optional parity bit is enabled by defining UART_TX_PARITY_EN (adds cfg_parity_odd_i).
module uart_tx_ctrl #(
   parameter int unsigned DATA_BITS = 8
) (
   input  logic                 clk_i,
   input  logic                 rstn_i,
   input  logic                 tx_valid_i,
   input  logic [DATA_BITS-1:0] tx_data_i,
   output logic                 tx_ready_o,
   input  logic                 cfg_stop2_i,
`ifdef UART_TX_PARITY_EN
   input  logic                 cfg_parity_odd_i,
`endif
   output logic                 baud_en_o,
   input  logic                 bit_done_i,
   output logic                 tx_o,
   output logic                 busy_o,
   output logic                 tx_done_o
);

   localparam int unsigned CNT_W = (DATA_BITS > 1) ? $clog2(DATA_BITS) : 1;

   typedef enum logic [2:0] {
      IDLE,
      START,
      DATA,
`ifdef UART_TX_PARITY_EN
      PARITY,
`endif
      STOP1,
      STOP2
   } state_e;

   state_e               state_q, state_d;
   logic [DATA_BITS-1:0] shift_q, shift_d;
   logic [CNT_W-1:0]     cnt_q, cnt_d;
   logic                 stop2_q, stop2_d;
`ifdef UART_TX_PARITY_EN
   logic                 par_q, par_d;
`endif
   logic                 tx_q, tx_d;
   logic                 ready_q, ready_d;
   logic                 busy_q, busy_d;
   logic                 done_q, done_d;

   logic                 accept_c;
   logic                 last_bit_c;

   assign accept_c   = tx_valid_i & ready_q;
   assign last_bit_c = (state_q == STOP2) | ((state_q == STOP1) & ~stop2_q);

   // Generator runs from the accept cycle and is dropped on the final bit_done so its counter restarts at 0
   assign baud_en_o  = accept_c | ((state_q != IDLE) & ~(last_bit_c & bit_done_i));

   assign tx_o       = tx_q;
   assign tx_ready_o = ready_q;
   assign busy_o     = busy_q;
   assign tx_done_o  = done_q;

   always_ff @(posedge clk_i or negedge rstn_i) begin
      if (!rstn_i) begin
         state_q <= IDLE;
         shift_q <= '0;
         cnt_q   <= '0;
         stop2_q <= 1'b0;
`ifdef UART_TX_PARITY_EN
         par_q   <= 1'b0;
`endif
         tx_q    <= 1'b1;
         ready_q <= 1'b0;
         busy_q  <= 1'b0;
         done_q  <= 1'b0;
      end else begin
         state_q <= state_d;
         shift_q <= shift_d;
         cnt_q   <= cnt_d;
         stop2_q <= stop2_d;
`ifdef UART_TX_PARITY_EN
         par_q   <= par_d;
`endif
         tx_q    <= tx_d;
         ready_q <= ready_d;
         busy_q  <= busy_d;
         done_q  <= done_d;
      end
   end

   always_comb begin
      state_d = state_q;
      shift_d = shift_q;
      cnt_d   = cnt_q;
      stop2_d = stop2_q;
`ifdef UART_TX_PARITY_EN
      par_d   = par_q;
`endif
      tx_d    = tx_q;
      ready_d = ready_q;
      busy_d  = busy_q;
      done_d  = 1'b0;

      case (state_q)
         IDLE: begin
            tx_d    = 1'b1;
            ready_d = 1'b1;
            busy_d  = 1'b0;
            if (accept_c) begin
               shift_d = tx_data_i;
               stop2_d = cfg_stop2_i;
`ifdef UART_TX_PARITY_EN
               par_d   = (^tx_data_i) ^ cfg_parity_odd_i;
`endif
               tx_d    = 1'b0;
               ready_d = 1'b0;
               busy_d  = 1'b1;
               state_d = START;
            end
         end
         START: begin
            if (bit_done_i) begin
               tx_d    = shift_q[0];
               shift_d = shift_q >> 1;
               cnt_d   = '0;
               state_d = DATA;
            end
         end
         DATA: begin
            if (bit_done_i) begin
               if (cnt_q == CNT_W'(DATA_BITS - 1)) begin
`ifdef UART_TX_PARITY_EN
                  tx_d    = par_q;
                  state_d = PARITY;
`else
                  tx_d    = 1'b1;
                  state_d = STOP1;
`endif
               end else begin
                  tx_d    = shift_q[0];
                  shift_d = shift_q >> 1;
                  cnt_d   = cnt_q + CNT_W'(1);
               end
            end
         end
`ifdef UART_TX_PARITY_EN
         PARITY: begin
            if (bit_done_i) begin
               tx_d    = 1'b1;
               state_d = STOP1;
            end
         end
`endif
         STOP1: begin
            if (bit_done_i) begin
               tx_d = 1'b1;
               if (stop2_q) begin
                  state_d = STOP2;
               end else begin
                  state_d = IDLE;
                  ready_d = 1'b1;
                  busy_d  = 1'b0;
                  done_d  = 1'b1;
               end
            end
         end
         STOP2: begin
            if (bit_done_i) begin
               tx_d    = 1'b1;
               state_d = IDLE;
               ready_d = 1'b1;
               busy_d  = 1'b0;
               done_d  = 1'b1;
            end
         end
         default: begin
            state_d = IDLE;
            tx_d    = 1'b1;
         end
      endcase
   end

endmodule

// File: tb/tb_uart_tx_ctrl.sv
// Scoreboard bench for uart_tx_ctrl with a behavioural baud generator; frames are captured off tx_o
// and compared against hand-computed bit sequences. Exercises parity too when UART_TX_PARITY_EN is defined.
`timescale 1ns/1ps
module tb_uart_tx_ctrl;

   localparam int unsigned DATA_BITS = 8;
`ifdef UART_TX_PARITY_EN
   localparam bit PAR_EN = 1'b1;
`else
   localparam bit PAR_EN = 1'b0;
`endif

   typedef struct {
      logic [15:0] bits;
      int          nbits;
      int          bt;
      bit          b2b;
   } exp_t;

   logic                 clk;
   logic                 rstn;
   logic                 tx_valid;
   logic [DATA_BITS-1:0] tx_data;
   logic                 tx_ready;
   logic                 cfg_stop2;
`ifdef UART_TX_PARITY_EN
   logic                 cfg_parity_odd;
`endif
   logic                 baud_en;
   logic                 bit_done;
   logic                 tx;
   logic                 busy;
   logic                 tx_done;

   int                   div;
   logic [7:0]           bcnt;

   exp_t                 exp_q[$];
   int                   chk_cnt = 0;
   int                   pass_cnt = 0;

   uart_tx_ctrl #(.DATA_BITS(DATA_BITS)) dut (
      .clk_i            (clk),
      .rstn_i           (rstn),
      .tx_valid_i       (tx_valid),
      .tx_data_i        (tx_data),
      .tx_ready_o       (tx_ready),
      .cfg_stop2_i      (cfg_stop2),
`ifdef UART_TX_PARITY_EN
      .cfg_parity_odd_i (cfg_parity_odd),
`endif
      .baud_en_o        (baud_en),
      .bit_done_i       (bit_done),
      .tx_o             (tx),
      .busy_o           (busy),
      .tx_done_o        (tx_done)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   initial begin
      #2_000_000;
      $display("FAIL watchdog: simulation did not finish in time");
      $fatal(1, "watchdog");
   end

   // Baud generator model: bit_done pulses for one cycle every div+1 enabled clocks
   always @(posedge clk or negedge rstn) begin
      if (!rstn) begin
         bcnt     <= 8'd0;
         bit_done <= 1'b0;
      end else begin
         bit_done <= 1'b0;
         if (baud_en) begin
            if (bcnt == 8'(div)) begin
               bcnt     <= 8'd0;
               bit_done <= 1'b1;
            end else begin
               bcnt <= bcnt + 8'd1;
            end
         end
      end
   end

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
      chk_cnt++;
      if (act === req) pass_cnt++;
      else $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, req);
   endtask

   // Start+data bits are hand-computed per vector; parity and stop bits appended per configuration
   function automatic exp_t mk(input logic [8:0] low9, input logic par, input logic s2, input bit b2b);
      exp_t e;
      int   k;
      e.bits       = '0;
      e.bits[8:0]  = low9;
      k            = 9;
      if (PAR_EN) begin
         e.bits[k] = par;
         k++;
      end
      e.bits[k] = 1'b1;
      k++;
      if (s2) begin
         e.bits[k] = 1'b1;
         k++;
      end
      e.nbits = k;
      e.bt    = div + 1;
      e.b2b   = b2b;
      return e;
   endfunction

   // Monitor: captures tx_o from the start bit until tx_done_o, then scores the frame
   int   cyc = 0;
   bit   cap_on = 1'b0;
   bit   done_prev = 1'b0;
   int   n = 0;
   int   gap = 0;
   int   last_done = -100;
   logic samples [0:511];

   task automatic finish_frame();
      exp_t        e;
      logic [15:0] obs;
      int          glitch;
      int          idx;
      if (exp_q.size() == 0) begin
         check("unexpected_frame", 32'd1, 32'd0);
         return;
      end
      e      = exp_q.pop_front();
      obs    = '0;
      glitch = 0;
      check("frame_len", 32'(n), 32'(e.nbits * e.bt));
      for (int k = 0; k < e.nbits; k++) begin
         idx = k * e.bt;
         if (idx < n && idx < 512) obs[k] = samples[idx];
         for (int j = 0; j < e.bt; j++) begin
            idx = k * e.bt + j;
            if (idx < n && idx < 512 && samples[idx] !== obs[k]) glitch++;
         end
      end
      check("frame_bits", 32'(obs), 32'(e.bits));
      check("frame_glitch", 32'(glitch), 32'd0);
      check("idle_line", 32'(tx), 32'd1);
      if (e.b2b) check("b2b_gap", 32'(gap), 32'd1);
   endtask

   always @(negedge clk) begin
      if (!rstn) begin
         cap_on    = 1'b0;
         done_prev = 1'b0;
      end else begin
         if (done_prev) check("done_pulse", 32'(tx_done), 32'd0);
         done_prev = tx_done;
         if (!cap_on && busy && !tx) begin
            cap_on = 1'b1;
            n      = 0;
            gap    = cyc - last_done;
         end
         if (cap_on) begin
            if (tx_done) begin
               cap_on    = 1'b0;
               last_done = cyc;
               finish_frame();
            end else begin
               if (n < 512) samples[n] = tx;
               n++;
            end
         end
      end
      cyc++;
   end

   task automatic send(input logic [7:0] d, input logic s2, input logic [8:0] low9,
                       input logic par, input bit b2b);
      int w;
      @(negedge clk);
      tx_valid  = 1'b1;
      tx_data   = d;
      cfg_stop2 = s2;
      w = 0;
      while (!tx_ready && w < 2000) begin
         @(negedge clk);
         w++;
      end
      if (!tx_ready) begin
         check("accept_timeout", 32'd0, 32'd1);
         tx_valid = 1'b0;
         return;
      end
      exp_q.push_back(mk(low9, par, s2, b2b));
      @(posedge clk);
   endtask

   task automatic drop_valid();
      @(negedge clk);
      tx_valid = 1'b0;
   endtask

   task automatic wait_idle();
      int w;
      w = 0;
      while (exp_q.size() != 0 && w < 5000) begin
         @(negedge clk);
         w++;
      end
      if (exp_q.size() != 0) begin
         check("frame_timeout", 32'(exp_q.size()), 32'd0);
         exp_q.delete();
      end
      repeat (2) @(negedge clk);
   endtask

   initial begin
      rstn      = 1'b0;
      tx_valid  = 1'b0;
      tx_data   = '0;
      cfg_stop2 = 1'b0;
`ifdef UART_TX_PARITY_EN
      cfg_parity_odd = 1'b0;
`endif
      div = 3;

      // Reset held for 5 cycles
      repeat (5) @(negedge clk);
      check("rst_tx", 32'(tx), 32'd1);
      check("rst_baud_en", 32'(baud_en), 32'd0);
      check("rst_ready", 32'(tx_ready), 32'd0);
      check("rst_busy", 32'(busy), 32'd0);
      check("rst_done", 32'(tx_done), 32'd0);
      rstn = 1'b1;
      #1;
      check("ready_before_edge", 32'(tx_ready), 32'd0);
      @(negedge clk);
      check("ready_after_release", 32'(tx_ready), 32'd1);

      // Basic frame 0xA5, 4-clock bits
      div = 3;
      send(8'hA5, 1'b0, 9'b101001010, 1'b0, 1'b0);
      drop_valid();
      wait_idle();

      // Back-to-back 0x00 then 0xFF with valid held
      send(8'h00, 1'b0, 9'b000000000, 1'b0, 1'b0);
      send(8'hFF, 1'b0, 9'b111111110, 1'b0, 1'b1);
      drop_valid();
      wait_idle();

      // Two stop bits at one clock per bit
      div = 0;
      send(8'h3C, 1'b1, 9'b001111000, 1'b0, 1'b0);
      drop_valid();
      wait_idle();

      // Reset during data bit 4 of 0xA5 (that bit is 0)
      div = 3;
      send(8'hA5, 1'b0, 9'b101001010, 1'b0, 1'b0);
      drop_valid();
      repeat (20) @(posedge clk);
      @(negedge clk);
      check("pre_rst_busy", 32'(busy), 32'd1);
      check("pre_rst_tx", 32'(tx), 32'd0);
      rstn = 1'b0;
      #1;
      check("mid_rst_tx", 32'(tx), 32'd1);
      check("mid_rst_busy", 32'(busy), 32'd0);
      check("mid_rst_baud_en", 32'(baud_en), 32'd0);
      exp_q.delete();
      repeat (3) @(negedge clk);
      rstn = 1'b1;
      @(negedge clk);
      send(8'h5A, 1'b0, 9'b010110100, 1'b0, 1'b0);
      drop_valid();
      wait_idle();

`ifdef UART_TX_PARITY_EN
      // Parity on 0x07: even gives 1, odd gives 0
      div = 1;
      cfg_parity_odd = 1'b0;
      send(8'h07, 1'b0, 9'b000001110, 1'b1, 1'b0);
      drop_valid();
      wait_idle();
      cfg_parity_odd = 1'b1;
      send(8'h07, 1'b0, 9'b000001110, 1'b0, 1'b0);
      drop_valid();
      wait_idle();
`endif

      repeat (10) @(negedge clk);
      check("scoreboard_drain", 32'(exp_q.size()), 32'd0);
      $display("%0d/%0d checks passed", pass_cnt, chk_cnt);
      $finish;
   end

endmodule
